pmem_responder: RTL and testbench



---
 rtl/pmem_responder.sv | 121 ++++++++++++
 tb/tb_pmem_responder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pmem_responder.sv
// Line-granular physical memory responder for the cache pmem port.
// Answers one read or write per request with a one-cycle resp pulse after LATENCY cycles.
module pmem_responder #(
  parameter int LATENCY    = 4,
  parameter int INDEX_BITS = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [15:0]  pmem_address,
  input  logic [127:0] pmem_wdata,
  output logic         pmem_resp,
  output logic [127:0] pmem_rdata,
  output logic         proto_err
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  localparam logic [7:0] CNT_INIT =
    (LATENCY > 1) ? 8'(LATENCY - 2) : 8'd0;

  state_t                r_state;
  state_t                w_state_n;
  logic [7:0]            r_cnt;
  logic [7:0]            w_cnt_n;
  logic                  r_op_wr;
  logic                  w_op_wr_n;
  logic [INDEX_BITS-1:0] r_idx;
  logic [INDEX_BITS-1:0] w_idx_n;
  logic [127:0]          r_wdata;
  logic [127:0]          w_wdata_n;
  logic [127:0]          r_rdata;
  logic [127:0]          w_rdata_n;
  logic                  r_err;
  logic                  w_err_n;
  logic                  w_req_held;
  logic                  w_unused_addr;

  logic [127:0] r_mem [2**INDEX_BITS];

  assign w_req_held = r_op_wr ? pmem_write : pmem_read;
  assign w_unused_addr =
    ^{pmem_address[15:INDEX_BITS+4], pmem_address[3:0]};

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_op_wr_n = r_op_wr;
    w_idx_n   = r_idx;
    w_wdata_n = r_wdata;
    w_rdata_n = r_rdata;
    w_err_n   = r_err;
    unique case (r_state)
      IDLE: begin
        unique case (1'b1)
          (pmem_read && pmem_write): begin
            w_err_n = 1'b1;
          end
          (pmem_read ^ pmem_write): begin
            w_op_wr_n = pmem_write;
            w_idx_n   = pmem_address[INDEX_BITS+3:4];
            w_cnt_n   = CNT_INIT;
            if (pmem_write) w_wdata_n = pmem_wdata;
            w_state_n = (LATENCY == 1) ? RESP : BUSY;
          end
          default: ;
        endcase
      end
      BUSY: begin
        if (!w_req_held) begin
          w_state_n = IDLE;
          w_err_n   = 1'b1;
        end else if (r_cnt == 8'd0) begin
          w_state_n = RESP;
        end else begin
          w_cnt_n = r_cnt - 8'd1;
        end
      end
      RESP: w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
    // read data is captured on the edge entering RESP
    if (r_state != RESP && w_state_n == RESP && !w_op_wr_n)
      w_rdata_n = r_mem[w_idx_n];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
      r_op_wr <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_op_wr <= w_op_wr_n;
      r_idx   <= w_idx_n;
      r_wdata <= w_wdata_n;
      r_rdata <= w_rdata_n;
      r_err   <= w_err_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && r_state == RESP && r_op_wr)
      r_mem[r_idx] <= r_wdata;
  end

  assign pmem_resp  = (r_state == RESP);
  assign pmem_rdata = r_rdata;
  assign proto_err  = r_err;

endmodule

// File: tb/tb_pmem_responder.sv
// Scoreboard bench for pmem_responder: directed cache-side transactions.
// Main instance at LATENCY=4, plus LATENCY=1 and LATENCY=7 instances.
module tb_pmem_responder;

  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         pmem_read = 1'b0;
  logic         pmem_write = 1'b0;
  logic [15:0]  pmem_address = '0;
  logic [127:0] pmem_wdata = '0;
  logic         pmem_resp;
  logic [127:0] pmem_rdata;
  logic         proto_err;

  logic         rd1 = 1'b0;
  logic         rd7 = 1'b0;
  logic         resp1, resp7, err1, err7;
  logic [127:0] rdata1, rdata7;
  logic         lo = 1'b0;
  logic [15:0]  a0 = '0;
  logic [127:0] d0 = '0;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    bit           rd;
    logic [127:0] d;
    int           c;
  } exp_t;
  exp_t q[$];

  localparam logic [127:0] A  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] X  = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
  localparam logic [127:0] B  = 128'h1357_9BDF_2468_ACE0_1357_9BDF_2468_ACE0;
  localparam logic [127:0] C  = 128'hC0C0_C0C0_C0C0_C0C0_0C0C_0C0C_0C0C_0C0C;
  localparam logic [127:0] B2 = 128'h5555_5555_5555_5555_5555_5555_5555_5555;
  localparam logic [127:0] AA = 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA;

  pmem_responder #(.LATENCY(LAT), .INDEX_BITS(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
    .proto_err(proto_err)
  );

  pmem_responder #(.LATENCY(1), .INDEX_BITS(5)) u_l1 (
    .clk(clk), .rst_n(rst_n),
    .pmem_read(rd1), .pmem_write(lo),
    .pmem_address(a0), .pmem_wdata(d0),
    .pmem_resp(resp1), .pmem_rdata(rdata1),
    .proto_err(err1)
  );

  pmem_responder #(.LATENCY(7), .INDEX_BITS(5)) u_l7 (
    .clk(clk), .rst_n(rst_n),
    .pmem_read(rd7), .pmem_write(lo),
    .pmem_address(a0), .pmem_wdata(d0),
    .pmem_resp(resp7), .pmem_rdata(rdata7),
    .proto_err(err7)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && pmem_resp) begin
        if (q.size() == 0) begin
          chk("unexpected_resp", 128'(cyc), 128'(-1));
        end else begin
          e = q.pop_front();
          chk("resp_cycle", 128'(cyc), 128'(e.c));
          if (e.rd) chk("rdata", pmem_rdata, e.d);
        end
      end
    end
  end

  task automatic do_op(input bit rd, input logic [15:0] a,
                       input logic [127:0] wd,
                       input logic [127:0] exp);
    exp_t e;
    int n;
    bit seen;
    e.rd = rd;
    e.d  = exp;
    e.c  = cyc + LAT;
    q.push_back(e);
    pmem_address = a;
    pmem_wdata   = wd;
    pmem_read    = rd;
    pmem_write   = !rd;
    n = 0;
    seen = 0;
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (pmem_resp) seen = 1;
    end
    if (!seen) chk("resp_timeout", 128'(n), 128'(LAT));
    @(posedge clk); #1;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp", 128'(pmem_resp), 128'(0));
    chk("rst_rdata", pmem_rdata, 128'(0));
    chk("rst_err", 128'(proto_err), 128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(0, 16'h0040, A, '0);
    do_op(1, 16'h004E, '0, A);
    chk("err_clean", 128'(proto_err), 128'(0));

    do_op(0, 16'h0000, X, '0);
    do_op(1, 16'h0200, '0, X);

    do_op(0, 16'h0100, B, '0);
    pmem_address = 16'h0100;
    pmem_wdata   = C;
    pmem_write   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("inflight_resp", 128'(pmem_resp), 128'(0));
    chk("inflight_rdata", pmem_rdata, 128'(0));
    chk("inflight_err", 128'(proto_err), 128'(0));
    pmem_write = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    do_op(1, 16'h0100, '0, B);

    do_op(0, 16'h0080, B2, '0);
    pmem_address = 16'h0080;
    pmem_wdata   = AA;
    pmem_write   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    pmem_write = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("abort_err", 128'(proto_err), 128'(1));
    do_op(1, 16'h0080, '0, B2);
    repeat (2) @(posedge clk);
    #1;
    chk("rdata_hold", pmem_rdata, B2);

    do_reset();
    chk("err_cleared", 128'(proto_err), 128'(0));
    pmem_read  = 1'b1;
    pmem_write = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("illegal_err", 128'(proto_err), 128'(1));
    do_op(1, 16'h0040, '0, A);

    rd1 = 1'b1;
    rd7 = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      chk($sformatf("l1_resp_%0d", k), 128'(resp1), 128'(k == 1));
      chk($sformatf("l7_resp_%0d", k), 128'(resp7), 128'(k == 7));
      if (resp1) rd1 = 1'b0;
      if (resp7) rd7 = 1'b0;
    end
    chk("l1_err", 128'(err1), 128'(0));
    chk("l7_err", 128'(err7), 128'(0));

    repeat (3) @(posedge clk);
    chk("queue_empty", 128'(q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
